// File: rtl/program_sequencer.sv
// program_sequencer: run-control FSM for the fetch stage.
// Holds a table of program start addresses, launches the selected
// program on a level request, lets the PC run until a halt retires,
// then reports completion and the number of RUN cycles.
// Ports:
//   CLK, Reset_n          clock, synchronous active-low reset
//   Req, Prog_Sel         run request (level) and program index
//   Halt, Branch_Req,Zero decode/ALU status, used only in RUN
//   Cfg_We/Idx/Addr       start-address table write port
//   Start, Start_Addr     PC pin/load control to the fetch unit
//   Branch                take-branch to the fetch unit (combinational)
//   Busy, Done, Err       status (Err pulses on a rejected request)
//   Cycles                RUN cycles of the current or last program
module program_sequencer #(
   parameter int NUM_PROG = 3,
   parameter int ADDR_W   = 8,
   parameter int CYC_W    = 16
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              Req,
   input  logic [1:0]        Prog_Sel,
   input  logic              Halt,
   input  logic              Branch_Req,
   input  logic              Zero,
   input  logic              Cfg_We,
   input  logic [1:0]        Cfg_Idx,
   input  logic [ADDR_W-1:0] Cfg_Addr,
   output logic              Start,
   output logic [ADDR_W-1:0] Start_Addr,
   output logic              Branch,
   output logic              Busy,
   output logic              Done,
   output logic              Err,
   output logic [CYC_W-1:0]  Cycles
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [ADDR_W-1:0] r_tab [NUM_PROG];
   logic [ADDR_W-1:0] r_start_addr;
   logic [CYC_W-1:0]  r_cycles;
   logic              r_err;

   logic              w_sel_ok;
   logic              w_idx_ok;
   logic              w_accept;
   logic              w_reject;

   assign w_sel_ok = (int'(Prog_Sel) < NUM_PROG);
   assign w_idx_ok = (int'(Cfg_Idx) < NUM_PROG);
   assign w_accept = (r_state == S_IDLE) && Req && w_sel_ok;
   assign w_reject = (r_state == S_IDLE) && Req && !w_sel_ok;

   // State register
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_next = S_LOAD;
         S_LOAD: w_next = S_RUN;
         S_RUN:  if (Halt) w_next = S_DONE;
         S_DONE: if (!Req) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode; halt suppresses a same-cycle branch
   always_comb begin
      Start  = (r_state != S_RUN);
      Busy   = (r_state == S_LOAD) || (r_state == S_RUN);
      Done   = (r_state == S_DONE);
      Branch = (r_state == S_RUN) && Branch_Req && Zero && !Halt;
   end

   // Table, launch address, cycle counter and error pulse.
   // The launch reads the pre-write table entry on a collision.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_PROG; i++) begin
            r_tab[i] <= '0;
         end
         r_start_addr <= '0;
         r_cycles     <= '0;
         r_err        <= 1'b0;
      end else begin
         r_err <= w_reject;
         if (Cfg_We && w_idx_ok) begin
            r_tab[Cfg_Idx] <= Cfg_Addr;
         end
         if (w_accept) begin
            r_start_addr <= r_tab[Prog_Sel];
            r_cycles     <= '0;
         end else if ((r_state == S_RUN) && (r_cycles != '1)) begin
            r_cycles <= r_cycles + CYC_W'(1);
         end
      end
   end

   assign Start_Addr = r_start_addr;
   assign Cycles     = r_cycles;
   assign Err        = r_err;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: self-checking bench for program_sequencer.
// Directed vector table, hand sequences and random traffic vs a model.
module tb_program_sequencer;

   logic       CLK;
   logic       Reset_n;
   logic       Req;
   logic [1:0] Prog_Sel;
   logic       Halt;
   logic       Branch_Req;
   logic       Zero;
   logic       Cfg_We;
   logic [1:0] Cfg_Idx;
   logic [7:0] Cfg_Addr;
   logic       Start;
   logic [7:0] Start_Addr;
   logic       Branch;
   logic       Busy;
   logic       Done;
   logic       Err;
   logic [15:0] Cycles;

   int n_chk;
   int n_fail;

   program_sequencer #(
      .NUM_PROG(3),
      .ADDR_W(8),
      .CYC_W(16)
   ) dut (
      .CLK(CLK),
      .Reset_n(Reset_n),
      .Req(Req),
      .Prog_Sel(Prog_Sel),
      .Halt(Halt),
      .Branch_Req(Branch_Req),
      .Zero(Zero),
      .Cfg_We(Cfg_We),
      .Cfg_Idx(Cfg_Idx),
      .Cfg_Addr(Cfg_Addr),
      .Start(Start),
      .Start_Addr(Start_Addr),
      .Branch(Branch),
      .Busy(Busy),
      .Done(Done),
      .Err(Err),
      .Cycles(Cycles)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish act=running req=finished");
      $fatal(1);
   end

   // Reference model: run phase, launch address, run-cycle count,
   // pending error pulse and the start-address table.
   typedef enum int {P_IDLE, P_LOAD, P_RUN, P_DONE} phase_t;
   phase_t     m_ph;
   logic [7:0] m_tab [3];
   logic [7:0] m_addr;
   int         m_cyc;
   logic       m_err;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [7:0] tab_old [3];
      for (int i = 0; i < 3; i++) tab_old[i] = m_tab[i];
      if (!Reset_n) begin
         m_ph   = P_IDLE;
         m_addr = 8'h00;
         m_cyc  = 0;
         m_err  = 1'b0;
         for (int i = 0; i < 3; i++) m_tab[i] = 8'h00;
         return;
      end
      m_err = 1'b0;
      if (Cfg_We && Cfg_Idx < 2'd3) m_tab[Cfg_Idx] = Cfg_Addr;
      case (m_ph)
         P_IDLE: begin
            if (Req && Prog_Sel < 2'd3) begin
               m_addr = tab_old[Prog_Sel];
               m_cyc  = 0;
               m_ph   = P_LOAD;
            end else if (Req) begin
               m_err = 1'b1;
            end
         end
         P_LOAD: m_ph = P_RUN;
         P_RUN: begin
            if (m_cyc < 65535) m_cyc = m_cyc + 1;
            if (Halt) m_ph = P_DONE;
         end
         default: if (!Req) m_ph = P_IDLE;
      endcase
   endtask

   // Outputs are sampled mid-low-phase; inputs change at negedge.
   task automatic check_model();
      #1;
      chk("m_start", 32'(Start), 32'(m_ph != P_RUN));
      chk("m_busy", 32'(Busy), 32'(m_ph == P_LOAD || m_ph == P_RUN));
      chk("m_done", 32'(Done), 32'(m_ph == P_DONE));
      chk("m_err", 32'(Err), 32'(m_err));
      chk("m_branch", 32'(Branch),
          32'(m_ph == P_RUN && Branch_Req && Zero && !Halt));
      chk("m_addr", 32'(Start_Addr), 32'(m_addr));
      chk("m_cycles", 32'(Cycles), 32'(m_cyc));
   endtask

   task automatic adv();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
   endtask

   task automatic cyc();
      check_model();
      adv();
   endtask

   task automatic idle_in();
      Req = 0; Prog_Sel = 0; Halt = 0; Branch_Req = 0; Zero = 0;
      Cfg_We = 0; Cfg_Idx = 0; Cfg_Addr = 0;
   endtask

   typedef struct {
      logic       req;
      logic [1:0] sel;
      logic       halt;
      logic       br;
      logic       z;
      logic       we;
      logic [1:0] idx;
      logic [7:0] ca;
      logic       e_start;
      logic       e_busy;
      logic       e_done;
      logic       e_err;
      logic       e_br;
      logic [7:0] e_addr;
      logic [15:0] e_cyc;
   } vec_t;

   vec_t tv [15];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      idle_in();
      Reset_n = 0;
      m_ph = P_IDLE; m_addr = 0; m_cyc = 0; m_err = 0;
      for (int i = 0; i < 3; i++) m_tab[i] = 0;
      @(negedge CLK);
      adv();
      adv();
      Reset_n = 1;

      // Reset and idle
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("rst_start", 32'(Start), 32'd1);
         chk("rst_addr", 32'(Start_Addr), 32'd0);
         chk("rst_status", {29'd0, Busy, Done, Err}, 32'd0);
         chk("rst_cycles", 32'(Cycles), 32'd0);
         adv();
      end

      // req sel halt br z we idx ca | start busy done err br addr cyc
      tv[0]  = '{0,0,0,0,0,1,1,8'h40, 1,0,0,0,0,8'h00,16'd0};
      tv[1]  = '{1,1,0,0,0,0,0,8'h00, 1,0,0,0,0,8'h00,16'd0};
      tv[2]  = '{1,1,0,0,0,0,0,8'h00, 1,1,0,0,0,8'h40,16'd0};
      tv[3]  = '{1,0,0,1,0,0,0,8'h00, 0,1,0,0,0,8'h40,16'd0};
      tv[4]  = '{1,0,0,1,1,0,0,8'h00, 0,1,0,0,1,8'h40,16'd1};
      tv[5]  = '{1,0,1,1,1,0,0,8'h00, 0,1,0,0,0,8'h40,16'd2};
      tv[6]  = '{1,0,0,0,0,0,0,8'h00, 1,0,1,0,0,8'h40,16'd3};
      tv[7]  = '{0,0,0,0,0,0,0,8'h00, 1,0,1,0,0,8'h40,16'd3};
      tv[8]  = '{0,0,0,1,1,0,0,8'h00, 1,0,0,0,0,8'h40,16'd3};
      tv[9]  = '{1,3,0,0,0,0,0,8'h00, 1,0,0,0,0,8'h40,16'd3};
      tv[10] = '{1,3,0,0,0,0,0,8'h00, 1,0,0,1,0,8'h40,16'd3};
      tv[11] = '{1,3,0,0,0,0,0,8'h00, 1,0,0,1,0,8'h40,16'd3};
      tv[12] = '{0,0,0,0,0,0,0,8'h00, 1,0,0,1,0,8'h40,16'd3};
      tv[13] = '{0,0,0,0,0,0,0,8'h00, 1,0,0,0,0,8'h40,16'd3};
      tv[14] = '{0,0,0,0,0,1,3,8'hFF, 1,0,0,0,0,8'h40,16'd3};

      for (int i = 0; i < 15; i++) begin
         Req = tv[i].req; Prog_Sel = tv[i].sel; Halt = tv[i].halt;
         Branch_Req = tv[i].br; Zero = tv[i].z; Cfg_We = tv[i].we;
         Cfg_Idx = tv[i].idx; Cfg_Addr = tv[i].ca;
         #1;
         chk($sformatf("tv%0d_start", i), 32'(Start), 32'(tv[i].e_start));
         chk($sformatf("tv%0d_busy", i), 32'(Busy), 32'(tv[i].e_busy));
         chk($sformatf("tv%0d_done", i), 32'(Done), 32'(tv[i].e_done));
         chk($sformatf("tv%0d_err", i), 32'(Err), 32'(tv[i].e_err));
         chk($sformatf("tv%0d_branch", i), 32'(Branch), 32'(tv[i].e_br));
         chk($sformatf("tv%0d_addr", i), 32'(Start_Addr), 32'(tv[i].e_addr));
         chk($sformatf("tv%0d_cycles", i), 32'(Cycles), 32'(tv[i].e_cyc));
         adv();
      end
      idle_in();

      // Basic launch, halt on the 10th RUN cycle, Req held through DONE
      Cfg_We = 1; Cfg_Idx = 2; Cfg_Addr = 8'h77;
      cyc();
      Cfg_We = 0; Req = 1; Prog_Sel = 2;
      cyc();
      chk("launch_load_busy", 32'(Busy), 32'd1);
      chk("launch_load_start", 32'(Start), 32'd1);
      cyc();
      chk("launch_run_addr", 32'(Start_Addr), 32'h77);
      chk("launch_run_start", 32'(Start), 32'd0);
      for (int i = 1; i <= 10; i++) begin
         Halt = (i == 10);
         cyc();
      end
      Halt = 0;
      chk("launch_done", 32'(Done), 32'd1);
      chk("launch_cycles", 32'(Cycles), 32'd10);
      cyc();
      chk("launch_no_relaunch", 32'(Done), 32'd1);
      Req = 0;
      cyc();
      chk("launch_idle", {29'd0, Start, Busy, Done}, 32'b100);

      // Write/launch collision on entry 0
      Cfg_We = 1; Cfg_Idx = 0; Cfg_Addr = 8'h10;
      cyc();
      Cfg_Addr = 8'h20; Req = 1; Prog_Sel = 0;
      cyc();
      Cfg_We = 0; Req = 0;
      cyc();
      chk("coll_old_addr", 32'(Start_Addr), 32'h10);
      Halt = 1;
      cyc();
      Halt = 0;
      cyc();
      Req = 1; Prog_Sel = 0;
      cyc();
      Req = 0;
      cyc();
      chk("coll_new_addr", 32'(Start_Addr), 32'h20);
      Halt = 1;
      cyc();
      Halt = 0;
      cyc();

      // Reset mid-run at Cycles=5
      Req = 1; Prog_Sel = 2;
      cyc();
      Req = 0;
      cyc();
      repeat (5) cyc();
      chk("midrst_pre_cycles", 32'(Cycles), 32'd5);
      Reset_n = 0;
      cyc();
      Reset_n = 1;
      chk("midrst_idle", {29'd0, Start, Busy, Done}, 32'b100);
      chk("midrst_cycles", 32'(Cycles), 32'd0);
      chk("midrst_addr", 32'(Start_Addr), 32'd0);
      Req = 1; Prog_Sel = 2;
      cyc();
      Req = 0;
      cyc();
      chk("midrst_tab_cleared", 32'(Start_Addr), 32'd0);

      // Long run to cycle-counter saturation
      repeat (65540) adv();
      chk("sat_cycles", 32'(Cycles), 32'hFFFF);
      Halt = 1;
      cyc();
      Halt = 0;
      chk("sat_done", 32'(Done), 32'd1);
      chk("sat_frozen", 32'(Cycles), 32'hFFFF);
      cyc();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         Reset_n    = ($urandom_range(0, 63) != 0);
         Req        = ($urandom_range(0, 2) != 0);
         Prog_Sel   = 2'($urandom_range(0, 3));
         Halt       = ($urandom_range(0, 7) == 0);
         Branch_Req = 1'($urandom);
         Zero       = 1'($urandom);
         Cfg_We     = ($urandom_range(0, 3) == 0);
         Cfg_Idx    = 2'($urandom_range(0, 3));
         Cfg_Addr   = 8'($urandom);
         cyc();
      end
      Reset_n = 1;
      idle_in();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
